// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGBW serial LED path; both the
// transmitter and the receiver take their default timing from here.
package rgb_pkg;

   localparam int DEF_WORD_BITS  = 32;
   // Pulse timing in clocks at 96 MHz: 0.3 us / 0.6 us / 1.25 us / 50 us.
   localparam int DEF_T0H_CLKS   = 29;
   localparam int DEF_T1H_CLKS   = 58;
   localparam int DEF_TBIT_CLKS  = 120;
   localparam int DEF_RESET_CLKS = 4800;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BIT   = 2'd1,
      ST_RESET = 2'd2
   } tx_state_t;

endpackage

// File: rtl/rgb_sbit_pulse.sv
// Bit-phase counter for one pulse-width-coded LED bit: high for T1H or T0H
// clocks depending on the bit value, bit period TBIT clocks.
module rgb_sbit_pulse
   import rgb_pkg::*;
#(
   parameter int T0H_CLKS  = DEF_T0H_CLKS,
   parameter int T1H_CLKS  = DEF_T1H_CLKS,
   parameter int TBIT_CLKS = DEF_TBIT_CLKS
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_bit_value,
   output logic o_pulse,
   output logic o_bit_end
);

   localparam int PW = $clog2(TBIT_CLKS);

   logic [PW-1:0] r_phase;
   logic          r_active;
   logic [PW-1:0] w_high;

   // NOTE: combinational blocks assign every output on every path, so no latch is inferred.
   always_comb begin
      w_high = PW'(T0H_CLKS);
      if (i_bit_value) w_high = PW'(T1H_CLKS);
   end

   assign o_pulse   = r_active && (r_phase < w_high);
   assign o_bit_end = r_active && (r_phase == PW'(TBIT_CLKS - 1));

   // A start on the last phase chains straight into the next bit with no gap.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_active <= 1'b0;
         r_phase  <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_phase  <= '0;
      end else if (r_active) begin
         if (r_phase == PW'(TBIT_CLKS - 1)) r_active <= 1'b0;
         else                               r_phase  <= r_phase + 1'b1;
      end
   end

endmodule

// File: rtl/rgb_wrd2sbit.sv
// WS281x/SK6812-style serial transmitter: one-word holding buffer, MSB-first
// pulse-width coding, and an on-request stream-reset (latch) low period.
module rgb_wrd2sbit
   import rgb_pkg::*;
#(
   parameter int WORD_BITS  = DEF_WORD_BITS,
   parameter int T0H_CLKS   = DEF_T0H_CLKS,
   parameter int T1H_CLKS   = DEF_T1H_CLKS,
   parameter int TBIT_CLKS  = DEF_TBIT_CLKS,
   parameter int RESET_CLKS = DEF_RESET_CLKS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_BITS-1:0] in_word,
   input  logic                 in_strobe,
   output logic                 in_ready,
   input  logic                 in_latch,
   output logic                 sout,
   output logic                 busy,
   output logic                 latch_done
);

   // T0H_CLKS < T1H_CLKS < TBIT_CLKS is assumed throughout.
   localparam int IW = (WORD_BITS  > 1) ? $clog2(WORD_BITS)  : 1;
   localparam int RW = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;

   tx_state_t            r_state;
   logic [WORD_BITS-1:0] r_buf;
   logic [WORD_BITS-1:0] r_shift;
   logic                 r_buf_valid;
   logic                 r_latch_pend;
   logic                 r_sout;
   logic [IW-1:0]        r_idx;
   logic [RW-1:0]        r_rst_cnt;

   logic w_accept;
   logic w_last_bit;
   logic w_bit_end;
   logic w_pulse;
   logic w_load;
   logic w_start;
   logic w_reset_end;

   assign w_accept    = in_strobe && !r_buf_valid;
   assign w_last_bit  = (r_idx == IW'(WORD_BITS - 1));
   assign w_reset_end = (r_state == ST_RESET) && (r_rst_cnt == RW'(RESET_CLKS - 1));
   assign w_load      = r_buf_valid &&
                        ((r_state == ST_IDLE) || ((r_state == ST_BIT) && w_bit_end && w_last_bit));
   assign w_start     = w_load || ((r_state == ST_BIT) && w_bit_end && !w_last_bit);

   assign in_ready   = !r_buf_valid;
   assign sout       = r_sout;
   assign busy       = (r_state != ST_IDLE) || r_buf_valid || r_latch_pend;
   assign latch_done = w_reset_end;

   rgb_sbit_pulse #(
      .T0H_CLKS  (T0H_CLKS),
      .T1H_CLKS  (T1H_CLKS),
      .TBIT_CLKS (TBIT_CLKS)
   ) u_pulse (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_start),
      .i_bit_value (r_shift[WORD_BITS-1]),
      .o_pulse     (w_pulse),
      .o_bit_end   (w_bit_end)
   );

   // NOTE: pure datapath flops carry no reset; the valid flag and FSM state decide when they matter.
   always_ff @(posedge clk) begin
      if (w_accept) r_buf <= in_word;
      if (w_load)
         r_shift <= r_buf;
      else if ((r_state == ST_BIT) && w_bit_end)
         r_shift <= r_shift << 1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_buf_valid  <= 1'b0;
         r_latch_pend <= 1'b0;
         r_idx        <= '0;
         r_rst_cnt    <= '0;
         r_sout       <= 1'b0;
      end else begin
         // Registering the pulse keeps sout free of any input-to-output path.
         r_sout <= (r_state == ST_BIT) && w_pulse;

         if (w_accept)    r_buf_valid <= 1'b1;
         else if (w_load) r_buf_valid <= 1'b0;

         // A latch request arriving during RESET is dropped, not queued.
         if (w_reset_end)
            r_latch_pend <= 1'b0;
         else if (in_latch && (r_state != ST_RESET))
            r_latch_pend <= 1'b1;

         unique case (r_state)
            ST_IDLE: begin
               if (r_buf_valid) begin
                  r_state <= ST_BIT;
                  r_idx   <= '0;
               end else if (r_latch_pend) begin
                  r_state   <= ST_RESET;
                  r_rst_cnt <= '0;
               end
            end
            ST_BIT: begin
               if (w_bit_end) begin
                  if (!w_last_bit) begin
                     r_idx <= r_idx + 1'b1;
                  end else if (r_buf_valid) begin
                     r_idx <= '0;
                  end else if (r_latch_pend) begin
                     r_state   <= ST_RESET;
                     r_rst_cnt <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_RESET: begin
               if (w_reset_end) r_state   <= ST_IDLE;
               else             r_rst_cnt <= r_rst_cnt + 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_wrd2sbit.sv
// Scoreboard bench for rgb_wrd2sbit: stimulus queues expected pulses and
// latch_done cycles, a negedge monitor decodes sout and compares.
module tb_rgb_wrd2sbit;

   localparam int TBIT  = 120;
   localparam int T0H   = 29;
   localparam int T1H   = 58;
   localparam int WORD  = 3840;
   localparam int RSTC  = 4800;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_word = '0;
   logic        in_strobe = 1'b0;
   logic        in_latch = 1'b0;
   logic        in_ready;
   logic        sout;
   logic        busy;
   logic        latch_done;

   rgb_wrd2sbit dut (
      .clk        (clk),
      .rst        (rst),
      .in_word    (in_word),
      .in_strobe  (in_strobe),
      .in_ready   (in_ready),
      .in_latch   (in_latch),
      .sout       (sout),
      .busy       (busy),
      .latch_done (latch_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int rise;
      int high;
   } pulse_t;

   pulse_t exp_q[$];
   int     latch_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Expected pulse per bit, MSB first, rise-to-rise spacing of one bit period.
   function automatic void push_word(input logic [31:0] w, input int first_rise, input int nbits);
      for (int k = 0; k < nbits; k++)
         exp_q.push_back('{first_rise + TBIT * k, w[31-k] ? T1H : T0H});
   endfunction

   // Monitor: measures each sout high run at negedges.
   int     m_rise = 0;
   int     m_high = 0;
   logic   m_prev = 1'b0;
   pulse_t m_exp;

   always @(negedge clk) begin
      if (sout) begin
         if (!m_prev) begin
            m_rise = cyc;
            m_high = 0;
         end
         m_high++;
      end else if (m_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse_rise", m_rise, -1);
         end else begin
            m_exp = exp_q.pop_front();
            check("pulse_rise_cyc", m_rise, m_exp.rise);
            check("pulse_high_clks", m_high, m_exp.high);
         end
      end
      m_prev = sout;
      if (latch_done) begin
         if (latch_q.size() == 0) check("unexpected_latch_done", cyc, -1);
         else                     check("latch_done_cyc", cyc, latch_q.pop_front());
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Called at a negedge; returns the cycle of the accepting edge.
   task automatic send(input logic [31:0] w, input logic lat, output int n_acc);
      bit done = 1'b0;
      n_acc     = -1;
      in_word   = w;
      in_strobe = 1'b1;
      in_latch  = lat;
      for (int t = 0; t < 20000 && !done; t++) begin
         done = in_ready;
         @(negedge clk);
      end
      in_strobe = 1'b0;
      in_latch  = 1'b0;
      if (done) n_acc = cyc;
      check("send_accepted", int'(done), 1);
   endtask

   task automatic wait_idle(output int c);
      for (int t = 0; t < 20000 && busy; t++) @(negedge clk);
      c = cyc;
      check("busy_low_reached", int'(busy), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int n, n1, n2, n3, n4, n5, n6, c, bad;

   initial begin
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_sout", sout, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_latch_done", latch_done, 0);
      rst = 1'b1;

      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (sout !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("idle_quiet_bad_cycles", bad, 0);

      // Single word: 58, 29 x 30, 58 high runs.
      send(32'h8000_0001, 1'b0, n);
      push_word(32'h8000_0001, n + 2, 32);
      check("in_ready_while_buffered", in_ready, 0);
      @(negedge clk);
      check("in_ready_after_load", in_ready, 1);
      wait_idle(c);
      check("busy_fall_cyc", c, n + 1 + WORD);
      repeat (10) @(negedge clk);
      check("pulses_drained_single", exp_q.size(), 0);

      // Back-to-back words with no gap between them.
      send(32'hFFFF_FFFF, 1'b0, n1);
      push_word(32'hFFFF_FFFF, n1 + 2, 32);
      send(32'h0000_0000, 1'b0, n2);
      check("b2b_second_accept_cyc", n2, n1 + 2);
      push_word(32'h0000_0000, n1 + 2 + WORD, 32);
      for (int t = 0; t < 5000 && !in_ready; t++) @(negedge clk);
      check("b2b_in_ready_rise_cyc", cyc, n1 + 1 + WORD);
      wait_idle(c);
      check("b2b_busy_fall_cyc", c, n1 + 1 + 2 * WORD);
      repeat (10) @(negedge clk);
      check("pulses_drained_b2b", exp_q.size(), 0);

      // Word with latch, extra latches during RESET, word strobed during RESET.
      send(32'hA5C3_0F69, 1'b1, n3);
      push_word(32'hA5C3_0F69, n3 + 2, 32);
      latch_q.push_back(n3 + WORD + RSTC);
      wait_cyc(n3 + 1 + WORD + 100);
      check("busy_in_reset", busy, 1);
      in_latch = 1'b1;
      @(negedge clk);
      in_latch = 1'b0;
      wait_cyc(n3 + 4500);
      send(32'h0000_00FF, 1'b0, n4);
      check("reset_strobe_accept_cyc", n4, n3 + 4501);
      check("reset_strobe_in_ready", in_ready, 0);
      push_word(32'h0000_00FF, n3 + WORD + RSTC + 3, 32);
      wait_cyc(n3 + WORD + RSTC);
      check("latch_done_last_reset_cycle", latch_done, 1);
      in_latch = 1'b1;
      @(negedge clk);
      in_latch = 1'b0;
      check("latch_queue_drained", latch_q.size(), 0);
      wait_idle(c);
      check("post_reset_busy_fall_cyc", c, n3 + 2 + 2 * WORD + RSTC);
      repeat (10) @(negedge clk);
      check("pulses_drained_latch", exp_q.size(), 0);

      // Reset mid-word with a second word buffered.
      send(32'hF0F0_F0F0, 1'b0, n5);
      send(32'h1234_5678, 1'b0, n6);
      check("abort_second_accept_cyc", n6, n5 + 2);
      push_word(32'hF0F0_F0F0, n5 + 2, 10);
      exp_q.push_back('{n5 + 2 + 10 * TBIT, 6});
      wait_cyc(n5 + 2 + 10 * TBIT + 5);
      #2 rst = 1'b0;
      #1;
      check("abort_sout", sout, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (600) @(negedge clk);
      check("abort_busy_after_release", busy, 0);
      check("pulses_drained_abort", exp_q.size(), 0);
      check("latch_queue_final", latch_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
